// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared types and constants for the key debouncer
//
// Purpose: per-key FSM state encoding and the default debounce length.
// Ports:   none (package).
package key_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key channel: synchroniser, polarity fix, debounce FSM, pulses
//
// Purpose: turns one raw asynchronous button pin into a clean pressed level
//          plus one-cycle press/release pulses.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   key_raw     in   raw button pin
//   key_down    out  debounced level, 1 = pressed
//   key_press   out  one-cycle pulse on accepted press
//   key_release out  one-cycle pulse on accepted release
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_down,
  output logic key_press,
  output logic key_release
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser idles at the pin level of a released key.
  localparam logic            REL_LVL  = KEY_ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          pressed;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          down_q, down_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Internal sense after the synchroniser: 1 = pressed.
  assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    down_d  = down_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (pressed != down_q) begin
          state_d = ST_CHECK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (pressed == down_q) begin
          // Bounce back to the accepted level: drop the candidate silently.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          down_d  = ~down_q;
          press_d = ~down_q;
          rel_d   = down_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounced push-button bank with key-0 press counter
//
// Purpose: NUM_KEYS independent debounce channels; counts accepted key 0
//          presses, key 1 presses clear the count.
// Ports:
//   CLOCK_50    in   system clock
//   RESET       in   asynchronous active-high reset
//   KEY         in   raw button pins [NUM_KEYS]
//   key_down    out  debounced levels, 1 = pressed
//   key_press   out  one-cycle accepted-press pulses
//   key_release out  one-cycle accepted-release pulses
//   press_count out  8-bit key 0 press count (drives LEDG)
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          press_count
);

  logic       clr;
  logic [7:0] press_count_q, press_count_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_chan (
      .clk        (CLOCK_50),
      .rst        (RESET),
      .key_raw    (KEY[g]),
      .key_down   (key_down[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

  if (NUM_KEYS >= 2) begin : g_clr
    assign clr = key_press[1];
  end else begin : g_no_clr
    assign clr = 1'b0;
  end

  // Clear has priority over a same-cycle increment; increment wraps at 8 bits.
  always_comb begin
    press_count_d = press_count_q;
    if (clr) begin
      press_count_d = 8'd0;
    end else if (key_press[0]) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      press_count_q <= 8'd0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int DEB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] key_down, key_press, key_release;
  logic [7:0]    press_count;

  int checks = 0;
  int errors = 0;

  // Reference: every pin sample taken at a clock edge, in pressed sense.
  // A level is accepted once the DEB samples captured two to DEB+1 edges ago
  // all disagree with the currently accepted level.
  logic [NK-1:0] capq[$];
  logic [NK-1:0] m_down, m_press, m_rel;
  int            m_count;
  int            press0_seen, rel0_seen;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .KEY        (key),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .press_count(press_count)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    capq.delete();
    for (int i = 0; i < DEB + 2; i++) capq.push_back('0);
    m_down  = '0;
    m_press = '0;
    m_rel   = '0;
    m_count = 0;
  endfunction

  function automatic void model_edge();
    logic settled;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_press[1]) m_count = 0;
    else if (m_press[0]) m_count = (m_count + 1) % 256;
    capq.push_back(~key);
    if (capq.size() > DEB + 2) void'(capq.pop_front());
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < NK; i++) begin
      settled = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (capq[j][i] == m_down[i]) settled = 1'b0;
      end
      if (settled) begin
        m_down[i] = ~m_down[i];
        if (m_down[i]) m_press[i] = 1'b1;
        else           m_rel[i]   = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    checks++;
    assert (key_down === m_down) else begin
      errors++; $error("FAIL key_down obs=%b exp=%b", key_down, m_down);
    end
    checks++;
    assert (key_press === m_press) else begin
      errors++; $error("FAIL key_press obs=%b exp=%b", key_press, m_press);
    end
    checks++;
    assert (key_release === m_rel) else begin
      errors++; $error("FAIL key_release obs=%b exp=%b", key_release, m_rel);
    end
    checks++;
    assert (press_count === 8'(m_count)) else begin
      errors++; $error("FAIL press_count obs=%0d exp=%0d", press_count, m_count);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (key_press[0])   press0_seen++;
    if (key_release[0]) rel0_seen++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    int lat;
    logic found, both;

    // Reset state
    rst = 1'b1;
    key = '1;
    model_reset();
    @(negedge clk);
    check_outputs();
    steps(2);
    rst = 1'b0;

    // Idle with all keys released
    steps(50);
    checks++;
    assert (key_down === '0 && press_count === 8'd0) else begin
      errors++; $error("FAIL idle obs=%b/%0d exp=0/0", key_down, press_count);
    end

    // Clean press of key 0: pulse exactly DEB+1 edges after first capture
    key[0] = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (key_press[0]) begin
        lat = n;
        break;
      end
    end
    checks++;
    assert (lat == DEB + 1) else begin
      errors++; $error("FAIL press_latency obs=%0d exp=%0d", lat, DEB + 1);
    end
    steps(3);
    checks++;
    assert (press_count === 8'd1) else begin
      errors++; $error("FAIL first_count obs=%0d exp=1", press_count);
    end
    key[0] = 1'b1;
    steps(DEB + 4);

    // Bouncing key 0 never accepted
    press0_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (n % 3 == 0) key[0] = ~key[0];
      step();
    end
    key[0] = 1'b1;
    steps(DEB + 4);
    checks++;
    assert (press0_seen == 0 && key_down[0] === 1'b0) else begin
      errors++; $error("FAIL bounce obs=%0d/%b exp=0/0", press0_seen, key_down[0]);
    end

    // Key 1 clears the count
    key[1] = 1'b0;
    steps(DEB + 4);
    key[1] = 1'b1;
    steps(DEB + 4);
    checks++;
    assert (press_count === 8'd0) else begin
      errors++; $error("FAIL clear obs=%0d exp=0", press_count);
    end

    // 300 presses with random short bounces: count wraps to 44
    press0_seen = 0;
    rel0_seen   = 0;
    for (int p = 0; p < 300; p++) begin
      repeat ($urandom_range(0, 2)) begin
        key[0] = 1'b0;
        steps(int'($urandom_range(1, DEB - 2)));
        key[0] = 1'b1;
        steps(int'($urandom_range(1, 3)));
      end
      key[0] = 1'b0;
      steps(DEB + 3 + int'($urandom_range(0, 4)));
      key[0] = 1'b1;
      steps(DEB + 3 + int'($urandom_range(0, 4)));
    end
    checks++;
    assert (press_count === 8'd44) else begin
      errors++; $error("FAIL wrap_count obs=%0d exp=44", press_count);
    end
    checks++;
    assert (press0_seen == 300 && rel0_seen == 300) else begin
      errors++; $error("FAIL pulse_totals obs=%0d/%0d exp=300/300", press0_seen, rel0_seen);
    end

    // Keys 0 and 1 together: same-cycle pulses, clear wins
    key[1:0] = 2'b00;
    found = 1'b0;
    both  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (key_press[0]) begin
        found = 1'b1;
        both  = key_press[1];
        break;
      end
    end
    checks++;
    assert (found && both) else begin
      errors++; $error("FAIL simultaneous obs=%b%b exp=11", found, both);
    end
    steps(3);
    checks++;
    assert (press_count === 8'd0) else begin
      errors++; $error("FAIL clear_wins obs=%0d exp=0", press_count);
    end
    key[1:0] = 2'b11;
    steps(DEB + 4);

    // Reset mid-CHECK with key 2 held, then re-acceptance after reset
    key[2] = 1'b0;
    steps(4);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    steps(3);
    rst = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (key_press[2]) begin
        lat = n;
        break;
      end
    end
    checks++;
    assert (lat == DEB + 1) else begin
      errors++; $error("FAIL reset_relatch obs=%0d exp=%0d", lat, DEB + 1);
    end
    key[2] = 1'b1;
    steps(DEB + 4);

    // Random activity on all keys
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 5) == 0) key[i] = ~key[i];
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
